// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot barrier arbiter.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPENING = 2'd1,
        ST_PASS    = 2'd2,
        ST_CLOSING = 2'd3
    } state_t;

    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

    localparam int CAPACITY_DEF = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/parking_gate_arbiter_gate_timer.sv
// Loadable down-counter shared by the barrier phases; done flags the last cycle of a phase.
module gate_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Loaded with N, the phase lasts N cycles: done on the cycle the count reads 1.
    assign done = (cnt == W'(1));

endmodule

// File: rtl/parking_gate_arbiter.sv
// Single-barrier arbiter: round-robin entry/exit grants, barrier sequencing and occupancy count.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | barrier closed, sampling lane requests
//   ST_OPENING | barrier travelling open for OPEN_CYC cycles
//   ST_PASS    | barrier held open, waiting for car_pass or timeout
//   ST_CLOSING | barrier travelling closed for OPEN_CYC cycles
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY     = CAPACITY_DEF,
    parameter int CNT_W        = 4,
    parameter int OPEN_CYC     = 4,
    parameter int PASS_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ent_req,
    input  logic             ext_req,
    input  logic             car_pass,
    output logic             gate_open,
    output logic             gate_dir,
    output logic             grant_in,
    output logic             grant_out,
    output logic             deny_in,
    output logic             timeout_err,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int TMR_W = $clog2(max_int(OPEN_CYC, PASS_TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] OPEN_C = TMR_W'(OPEN_CYC);
    localparam logic [TMR_W-1:0] PASS_C = TMR_W'(PASS_TIMEOUT);

    state_t           state, state_nxt;
    logic             last_grant, last_grant_nxt;
    logic             gate_open_nxt, gate_dir_nxt;
    logic             grant_in_nxt, grant_out_nxt, deny_in_nxt, timeout_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             tmr_load, tmr_done;
    logic [TMR_W-1:0] tmr_val;
    logic             elig_in, elig_out, pick_in;

    assign full     = (count == CAP_C);
    assign empty    = (count == '0);
    assign busy     = (state != ST_IDLE);
    assign elig_in  = ent_req && !full;
    assign elig_out = ext_req && !empty;
    // Entry wins when it is the only candidate or when exit had the previous grant.
    assign pick_in  = elig_in && (!elig_out || (last_grant == DIR_OUT));

    gate_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= ST_IDLE;
            last_grant  <= DIR_OUT;
            gate_open   <= 1'b0;
            gate_dir    <= 1'b0;
            grant_in    <= 1'b0;
            grant_out   <= 1'b0;
            deny_in     <= 1'b0;
            timeout_err <= 1'b0;
            count       <= '0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            gate_open   <= gate_open_nxt;
            gate_dir    <= gate_dir_nxt;
            grant_in    <= grant_in_nxt;
            grant_out   <= grant_out_nxt;
            deny_in     <= deny_in_nxt;
            timeout_err <= timeout_nxt;
            count       <= count_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        gate_open_nxt  = gate_open;
        gate_dir_nxt   = gate_dir;
        grant_in_nxt   = 1'b0;
        grant_out_nxt  = 1'b0;
        deny_in_nxt    = 1'b0;
        timeout_nxt    = 1'b0;
        count_nxt      = count;
        tmr_load       = 1'b0;
        tmr_val        = OPEN_C;

        case (state)
            ST_IDLE: begin
                if (elig_in || elig_out) begin
                    state_nxt      = ST_OPENING;
                    gate_open_nxt  = 1'b1;
                    gate_dir_nxt   = pick_in ? DIR_IN : DIR_OUT;
                    last_grant_nxt = pick_in ? DIR_IN : DIR_OUT;
                    grant_in_nxt   = pick_in;
                    grant_out_nxt  = !pick_in;
                    tmr_load       = 1'b1;
                    tmr_val        = OPEN_C;
                end else if (ent_req && full) begin
                    deny_in_nxt = 1'b1;
                end
            end

            ST_OPENING: begin
                if (tmr_done) begin
                    state_nxt = ST_PASS;
                    tmr_load  = 1'b1;
                    tmr_val   = PASS_C;
                end
            end

            ST_PASS: begin
                // car_pass takes priority over a simultaneous expiry.
                if (car_pass || tmr_done) begin
                    state_nxt     = ST_CLOSING;
                    gate_open_nxt = 1'b0;
                    tmr_load      = 1'b1;
                    tmr_val       = OPEN_C;
                    if (car_pass) begin
                        if (gate_dir == DIR_IN) begin
                            if (count != CAP_C) count_nxt = count + 1'b1;
                        end else begin
                            if (count != '0) count_nxt = count - 1'b1;
                        end
                    end else begin
                        timeout_nxt = 1'b1;
                    end
                end
            end

            ST_CLOSING: begin
                if (tmr_done) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt     = ST_IDLE;
                gate_open_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed self-checking bench for parking_gate_arbiter (CAPACITY=10, OPEN_CYC=4, PASS_TIMEOUT=16).
module tb_parking_gate_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic       ent_req, ext_req, car_pass;
    logic       gate_open, gate_dir, grant_in, grant_out, deny_in, timeout_err, busy;
    logic [3:0] count;
    logic       full, empty;

    int n_assert = 0;
    int n_fail   = 0;

    parking_gate_arbiter #(
        .CAPACITY(10), .CNT_W(4), .OPEN_CYC(4), .PASS_TIMEOUT(16)
    ) dut (
        .clk(clk), .clr(clr), .ent_req(ent_req), .ext_req(ext_req), .car_pass(car_pass),
        .gate_open(gate_open), .gate_dir(gate_dir), .grant_in(grant_in), .grant_out(grant_out),
        .deny_in(deny_in), .timeout_err(timeout_err), .busy(busy), .count(count),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One full grant/open/pass/close cycle with the lane requests set by the caller.
    task automatic serve(input string tag, input logic exp_in, input logic [3:0] exp_cnt);
        tick();
        chk({tag, ".grant_in"}, grant_in, exp_in);
        chk({tag, ".grant_out"}, grant_out, !exp_in);
        chk({tag, ".gate_dir"}, gate_dir, exp_in);
        ticks(4);
        car_pass = 1'b1;
        tick();
        car_pass = 1'b0;
        chk({tag, ".count"}, count, exp_cnt);
        ticks(4);
        chk({tag, ".idle"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; ent_req = 1'b0; ext_req = 1'b0; car_pass = 1'b0;
        ticks(2);
        chk("rst.gate_open", gate_open, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.count", count, 4'd0);
        chk("rst.empty", empty, 1'b1);
        chk("rst.full", full, 1'b0);
        chk("rst.pulses", {grant_in, grant_out, deny_in, timeout_err}, 4'b0000);
        clr = 1'b0;
        tick();

        // single entry with exact phase timing
        ent_req = 1'b1;
        tick();
        ent_req = 1'b0;
        chk("t1.grant_in", grant_in, 1'b1);
        chk("t1.gate_open", gate_open, 1'b1);
        chk("t1.gate_dir", gate_dir, 1'b1);
        tick();
        chk("t1.grant_pulse_end", grant_in, 1'b0);
        ticks(2);
        car_pass = 1'b1;
        tick();
        chk("t1.pass_ignored_opening", count, 4'd0);
        chk("t1.open_in_pass", gate_open, 1'b1);
        tick();
        car_pass = 1'b0;
        chk("t1.count", count, 4'd1);
        chk("t1.closing", gate_open, 1'b0);
        chk("t1.busy_closing", busy, 1'b1);
        ticks(3);
        chk("t1.busy_c4", busy, 1'b1);
        tick();
        chk("t1.busy_drop", busy, 1'b0);

        // fill to 6, then one exit so the last grant was the exit lane
        ent_req = 1'b1;
        serve("fill2", 1'b1, 4'd2);
        serve("fill3", 1'b1, 4'd3);
        serve("fill4", 1'b1, 4'd4);
        serve("fill5", 1'b1, 4'd5);
        serve("fill6", 1'b1, 4'd6);
        ent_req = 1'b0;
        ext_req = 1'b1;
        serve("exit5", 1'b0, 4'd5);

        // both lanes held: in, out, in
        ent_req = 1'b1;
        serve("rr1", 1'b1, 4'd6);
        serve("rr2", 1'b0, 4'd5);
        serve("rr3", 1'b1, 4'd6);
        ext_req = 1'b0;
        serve("fill7", 1'b1, 4'd7);
        serve("fill8", 1'b1, 4'd8);
        serve("fill9", 1'b1, 4'd9);
        serve("fill10", 1'b1, 4'd10);
        chk("t3.full", full, 1'b1);

        // lot full: entry denied every sampled IDLE cycle
        tick();
        chk("t3.deny1", deny_in, 1'b1);
        chk("t3.gate_closed", gate_open, 1'b0);
        chk("t3.not_busy", busy, 1'b0);
        tick();
        chk("t3.deny2", deny_in, 1'b1);
        chk("t3.count", count, 4'd10);
        ent_req = 1'b0;
        tick();
        chk("t3.deny_end", deny_in, 1'b0);

        // full with both lanes: exit is granted and no deny
        ent_req = 1'b1; ext_req = 1'b1;
        tick();
        chk("full_both.grant_out", grant_out, 1'b1);
        chk("full_both.no_deny", deny_in, 1'b0);
        ent_req = 1'b0; ext_req = 1'b0;
        ticks(4);
        car_pass = 1'b1;
        tick();
        car_pass = 1'b0;
        chk("full_both.count", count, 4'd9);
        ticks(4);

        // timeout with no car
        ent_req = 1'b1;
        tick();
        ent_req = 1'b0;
        chk("t4.grant_in", grant_in, 1'b1);
        ticks(4);
        ticks(15);
        chk("t4.no_err_c16", timeout_err, 1'b0);
        chk("t4.open_c16", gate_open, 1'b1);
        tick();
        chk("t4.timeout_err", timeout_err, 1'b1);
        chk("t4.closing", gate_open, 1'b0);
        chk("t4.count", count, 4'd9);
        tick();
        chk("t4.err_pulse_end", timeout_err, 1'b0);
        ticks(2);
        chk("t4.busy_c4", busy, 1'b1);
        tick();
        chk("t4.idle", busy, 1'b0);

        // car_pass on the expiry cycle wins
        ent_req = 1'b1;
        tick();
        ent_req = 1'b0;
        ticks(4);
        ticks(15);
        car_pass = 1'b1;
        tick();
        car_pass = 1'b0;
        chk("tie.count", count, 4'd10);
        chk("tie.no_err", timeout_err, 1'b0);
        ticks(4);

        // exits down to 3
        ext_req = 1'b1;
        serve("exit9", 1'b0, 4'd9);
        serve("exit8", 1'b0, 4'd8);
        serve("exit7", 1'b0, 4'd7);
        serve("exit6", 1'b0, 4'd6);
        serve("exit5b", 1'b0, 4'd5);
        serve("exit4", 1'b0, 4'd4);
        serve("exit3", 1'b0, 4'd3);

        // clr mid-PASS
        tick();
        ext_req = 1'b0;
        ticks(6);
        chk("t6.open_before", gate_open, 1'b1);
        #2 clr = 1'b1;
        #1;
        chk("t6.gate_open_async", gate_open, 1'b0);
        chk("t6.count_async", count, 4'd0);
        chk("t6.busy_async", busy, 1'b0);
        #1 clr = 1'b0;
        tick();

        // empty lot: exit request ignored silently
        ext_req = 1'b1;
        tick();
        chk("t5.no_grant", {grant_in, grant_out}, 2'b00);
        chk("t5.no_deny", deny_in, 1'b0);
        chk("t5.busy", busy, 1'b0);
        chk("t5.empty", empty, 1'b1);
        ext_req = 1'b0;

        // normal entry after the clear
        ent_req = 1'b1;
        serve("post_clr", 1'b1, 4'd1);
        ent_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
